box_v_window_ctrl: RTL and testbench

- Sequencer in front of the 1x3 vertical fp16 box-filter convolution stage.
- Accepts a raster pixel stream and holds the two previous image rows in on-chip line buffers.
- Presents the convolution stage with one 3x1 vertical window per cycle, plus matching col/row/valid and a constant kernel; handles top/bottom borders.
- Drains the final row after each frame by stalling its input.

---
 rtl/box_v_window_ctrl_if.sv | 38 +++
 rtl/box_v_window_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_box_v_window_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/box_v_window_ctrl_if.sv
// rtl/box_v_window_ctrl_if.sv - pixel-in / window-out bundle for box_v_window_ctrl
//
// Purpose: groups the raster pixel input stream and the 3x1 window output
//          of the vertical box-filter sequencer into one interface.
// Signals:
//   data_i, col_i, row_i, valid_i : input pixel, its tags and valid
//   ready_o                       : input pixel accepted when valid_i && ready_o
//   window_o[3][1]                : [0]=row above, [1]=centre, [2]=row below
//   kernel_o[3][1]                : constant kernel taps
//   col_o, row_o, valid_o         : centre-pixel position and window valid
//   sync_err_o                    : sticky input tag / internal counter disagreement
// Modports: slave = sequencer side, master = pixel source / window sink side.

interface box_v_window_ctrl_if #(
  parameter int FP_WIDTH = 16
);
  logic [FP_WIDTH-1:0] data_i;
  logic [15:0]         col_i;
  logic [15:0]         row_i;
  logic                valid_i;
  logic                ready_o;
  logic [FP_WIDTH-1:0] window_o [3][1];
  logic [FP_WIDTH-1:0] kernel_o [3][1];
  logic [15:0]         col_o;
  logic [15:0]         row_o;
  logic                valid_o;
  logic                sync_err_o;

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output ready_o, window_o, kernel_o, col_o, row_o, valid_o, sync_err_o
  );

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  ready_o, window_o, kernel_o, col_o, row_o, valid_o, sync_err_o
  );
endinterface

// File: rtl/box_v_window_ctrl.sv
// rtl/box_v_window_ctrl.sv - 3x1 vertical window sequencer for the fp16 box filter
//
// Purpose: accepts a raster pixel stream, keeps the two previous rows in line
//          buffers and emits one registered 3x1 vertical window per accepted
//          pixel (centre = previous row). After the last pixel of a frame the
//          input is stalled while the final row is flushed with a bottom border.
// Ports:
//   clk_i : single clock
//   rst_i : synchronous, active-high reset
//   bus   : box_v_window_ctrl_if.slave (pixel input, window output, sync_err_o)
// Configuration macro:
//   BOX_V_REPLICATE_BORDER_EN : defined   -> border tap replicates the centre pixel
//                               undefined -> border tap is +0.0 (all-zero word)

module box_v_window_ctrl #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter logic [EXP_WIDTH+FRAC_WIDTH:0] KERNEL_VALUE = 16'h3555
) (
  input logic              clk_i,
  input logic              rst_i,
  box_v_window_ctrl_if.slave bus
);

  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int CW           = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t state, state_n;
  logic [15:0] col_cnt, col_n;
  logic [15:0] row_cnt, row_n;
  logic        sync_err, sync_n;

  // lb0 = row r-1, lb1 = row r-2 relative to the incoming row r
  logic [FP_WIDTH_REG-1:0] lb0 [IMAGE_WIDTH];
  logic [FP_WIDTH_REG-1:0] lb1 [IMAGE_WIDTH];
  logic [CW-1:0]           col_idx;
  logic [FP_WIDTH_REG-1:0] lb0_rd, lb1_rd, border;
  logic                    lb_we;

  logic                    accept;
  logic                    col_last, row_last;

  logic                    win_v_n;
  logic [FP_WIDTH_REG-1:0] top_n, mid_n, bot_n;
  logic [15:0]             col_out_n, row_out_n;

  logic                    valid_q;
  logic [FP_WIDTH_REG-1:0] top_q, mid_q, bot_q;
  logic [15:0]             col_q, row_q;

  // In FLUSH col_cnt doubles as the flush column, so one read port serves all states
  assign col_idx  = col_cnt[CW-1:0];
  assign lb0_rd   = lb0[col_idx];
  assign lb1_rd   = lb1[col_idx];
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);

`ifdef BOX_V_REPLICATE_BORDER_EN
  assign border = lb0_rd;
`else
  assign border = '0;
`endif

  // Ready depends on state only; the source holds its pixel while flushing
  assign bus.ready_o = (state != S_FLUSH);
  assign accept      = bus.valid_i && bus.ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      col_cnt  <= '0;
      row_cnt  <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      col_cnt  <= col_n;
      row_cnt  <= row_n;
      sync_err <= sync_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col_cnt;
    row_n     = row_cnt;
    sync_n    = sync_err;
    lb_we     = 1'b0;
    win_v_n   = 1'b0;
    top_n     = lb1_rd;
    mid_n     = lb0_rd;
    bot_n     = bus.data_i;
    col_out_n = col_cnt;
    row_out_n = row_cnt;

    case (state)
      S_IDLE: begin
        // Anything other than the frame origin is dropped to realign on (0,0)
        if (accept && bus.col_i == 16'd0 && bus.row_i == 16'd0) begin
          lb_we   = 1'b1;
          col_n   = 16'd1;
          state_n = S_FILL;
        end
      end

      S_FILL: begin
        if (accept) begin
          lb_we = 1'b1;
          if (col_last) begin
            col_n   = '0;
            row_n   = 16'd1;
            state_n = S_RUN;
          end else begin
            col_n = col_cnt + 16'd1;
          end
        end
      end

      S_RUN: begin
        if (accept) begin
          lb_we     = 1'b1;
          win_v_n   = 1'b1;
          top_n     = (row_cnt == 16'd1) ? border : lb1_rd;
          row_out_n = row_cnt - 16'd1;
          if (col_last) begin
            col_n = '0;
            // row_cnt stays at the last row so FLUSH reports it as the centre row
            if (row_last) state_n = S_FLUSH;
            else          row_n   = row_cnt + 16'd1;
          end else begin
            col_n = col_cnt + 16'd1;
          end
        end
      end

      S_FLUSH: begin
        win_v_n = 1'b1;
        bot_n   = border;
        if (col_last) begin
          col_n   = '0;
          row_n   = '0;
          state_n = S_IDLE;
        end else begin
          col_n = col_cnt + 16'd1;
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (accept && state != S_IDLE &&
        (bus.col_i != col_cnt || bus.row_i != row_cnt)) begin
      sync_n = 1'b1;
    end
  end

  // Line buffers are deliberately not reset; FILL rewrites every column of lb0
  always_ff @(posedge clk_i) begin
    if (lb_we && !rst_i) begin
      lb1[col_idx] <= lb0[col_idx];
      lb0[col_idx] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      valid_q <= win_v_n;
      if (win_v_n) begin
        top_q <= top_n;
        mid_q <= mid_n;
        bot_q <= bot_n;
        col_q <= col_out_n;
        row_q <= row_out_n;
      end
    end
  end

  assign bus.window_o[0][0] = top_q;
  assign bus.window_o[1][0] = mid_q;
  assign bus.window_o[2][0] = bot_q;
  assign bus.kernel_o[0][0] = KERNEL_VALUE;
  assign bus.kernel_o[1][0] = KERNEL_VALUE;
  assign bus.kernel_o[2][0] = KERNEL_VALUE;
  assign bus.col_o          = col_q;
  assign bus.row_o          = row_q;
  assign bus.valid_o        = valid_q;
  assign bus.sync_err_o     = sync_err;

endmodule

// File: tb/tb_box_v_window_ctrl.sv
// tb/tb_box_v_window_ctrl.sv - directed self-checking bench for box_v_window_ctrl

module tb_box_v_window_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  box_v_window_ctrl_if #(.FP_WIDTH(16)) bus ();

  box_v_window_ctrl #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .KERNEL_VALUE(16'h3555)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int          acc_cyc[$];
  logic [15:0] wt[$], wm[$], wb[$], wc[$], wr[$];
  int          wcyc[$];
  bit          rdy_hist [0:8191];

  // Accepts are seen at the negedge before the edge that takes them (cycle t);
  // outputs are sampled 1 time unit after the edge (cycle t+1).
  always @(negedge clk) if (bus.valid_i && bus.ready_o && !rst) acc_cyc.push_back(cyc);

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    rdy_hist[cyc & 8191] = bus.ready_o;
    if (bus.valid_o) begin
      wt.push_back(bus.window_o[0][0]);
      wm.push_back(bus.window_o[1][0]);
      wb.push_back(bus.window_o[2][0]);
      wc.push_back(bus.col_o);
      wr.push_back(bus.row_o);
      wcyc.push_back(cyc);
    end
  end

  function automatic logic [15:0] pix(input int base, input int c, input int r);
    return 16'(base + r * W + c + 1);
  endfunction

  function automatic logic [15:0] bord(input logic [15:0] centre);
`ifdef BOX_V_REPLICATE_BORDER_EN
    return centre;
`else
    return (centre & 16'h0000);
`endif
  endfunction

  // Expected {top, centre, bottom} for the i-th window of a frame
  function automatic logic [47:0] exp_win(input int base, input int i);
    int c, cr;
    logic [15:0] t, m, b;
    c  = i % W;
    cr = i / W;
    m  = pix(base, c, cr);
    t  = (cr == 0)     ? bord(m) : pix(base, c, cr - 1);
    b  = (cr == H - 1) ? bord(m) : pix(base, c, cr + 1);
    return {t, m, b};
  endfunction

  task automatic clear_mon();
    acc_cyc.delete(); wt.delete(); wm.delete(); wb.delete();
    wc.delete(); wr.delete(); wcyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_px(input logic [15:0] d, input int c, input int r);
    bit got;
    got = 1'b0;
    bus.data_i  = d;
    bus.col_i   = 16'(c);
    bus.row_i   = 16'(r);
    bus.valid_i = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.ready_o;
      @(posedge clk); #2;
    end
    bus.valid_i = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted, required accept within 40 cycles", c, r);
    end
  endtask

  task automatic send_frame(input int base, input int gap);
    for (int i = 0; i < N; i++) begin
      send_px(pix(base, i % W, i / W), i % W, i / W);
      if (i != N - 1) idle(gap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.ready_o); end
    n_cmp++; if (bus.sync_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_sync: got %b want 0", bus.sync_err_o); end
    n_cmp++; if ({bus.window_o[0][0], bus.window_o[1][0], bus.window_o[2][0], bus.col_o, bus.row_o} !== 80'h0) begin
      n_fail++; $display("FAIL rst_window: got %h %h %h col %0d row %0d want all 0",
                         bus.window_o[0][0], bus.window_o[1][0], bus.window_o[2][0], bus.col_o, bus.row_o);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.kernel_o[k][0] !== 16'h3555) begin
        n_fail++; $display("FAIL kernel_tap%0d: got %h want 3555", k, bus.kernel_o[k][0]);
      end
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_frame();
    int t;
    clear_mon();
    send_frame(0, 0);
    idle(W + 4);
    n_cmp++; if (wt.size() !== N) begin n_fail++; $display("FAIL frame_count: got %0d want %0d", wt.size(), N); end
    n_cmp++; if (acc_cyc.size() !== N) begin n_fail++; $display("FAIL frame_acc: got %0d want %0d", acc_cyc.size(), N); end
    if (wt.size() == N && acc_cyc.size() == N) begin
`ifdef BOX_V_REPLICATE_BORDER_EN
      n_cmp++; if ({wt[0], wm[0], wb[0]} !== {16'd1, 16'd1, 16'd5}) begin n_fail++; $display("FAIL first_win: got %0d,%0d,%0d want 1,1,5", wt[0], wm[0], wb[0]); end
      n_cmp++; if ({wt[N-1], wm[N-1], wb[N-1]} !== {16'd8, 16'd12, 16'd12}) begin n_fail++; $display("FAIL last_win: got %0d,%0d,%0d want 8,12,12", wt[N-1], wm[N-1], wb[N-1]); end
`else
      n_cmp++; if ({wt[0], wm[0], wb[0]} !== {16'd0, 16'd1, 16'd5}) begin n_fail++; $display("FAIL first_win: got %0d,%0d,%0d want 0,1,5", wt[0], wm[0], wb[0]); end
      n_cmp++; if ({wt[N-1], wm[N-1], wb[N-1]} !== {16'd8, 16'd12, 16'd0}) begin n_fail++; $display("FAIL last_win: got %0d,%0d,%0d want 8,12,0", wt[N-1], wm[N-1], wb[N-1]); end
`endif
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({wt[i], wm[i], wb[i], wc[i], wr[i]} !== {exp_win(0, i), 16'(i % W), 16'(i / W)}) begin
          n_fail++; $display("FAIL frame_win%0d: got %0d,%0d,%0d @(%0d,%0d) want %h @(%0d,%0d)",
                             i, wt[i], wm[i], wb[i], wc[i], wr[i], exp_win(0, i), i % W, i / W);
        end
        t = (i < N - W) ? acc_cyc[i + W] + 1 : acc_cyc[N-1] + 2 + (i - (N - W));
        n_cmp++;
        if (wcyc[i] !== t) begin n_fail++; $display("FAIL frame_time%0d: got cycle %0d want %0d", i, wcyc[i], t); end
      end
      for (int k = 1; k <= W + 1; k++) begin
        n_cmp++;
        if (rdy_hist[(acc_cyc[N-1] + k) & 8191] !== (k == W + 1)) begin
          n_fail++; $display("FAIL flush_ready_t+%0d: got %b want %b", k, rdy_hist[(acc_cyc[N-1] + k) & 8191], k == W + 1);
        end
      end
    end
    n_cmp++; if (bus.sync_err_o !== 1'b0) begin n_fail++; $display("FAIL frame_sync: got %b want 0", bus.sync_err_o); end
  endtask

  task automatic test_bubbles();
    clear_mon();
    send_frame(100, 2);
    idle(W + 4);
    n_cmp++; if (wt.size() !== N) begin n_fail++; $display("FAIL bub_count: got %0d want %0d", wt.size(), N); end
    if (wt.size() == N && acc_cyc.size() == N) begin
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if ({wt[i], wm[i], wb[i], wc[i], wr[i]} !== {exp_win(100, i), 16'(i % W), 16'(i / W)}) begin
          n_fail++; $display("FAIL bub_win%0d: got %0d,%0d,%0d @(%0d,%0d) want %h", i, wt[i], wm[i], wb[i], wc[i], wr[i], exp_win(100, i));
        end
        if (i < N - W) begin
          n_cmp++;
          if (wcyc[i] !== acc_cyc[i + W] + 1) begin
            n_fail++; $display("FAIL bub_time%0d: got cycle %0d want %0d", i, wcyc[i], acc_cyc[i + W] + 1);
          end
        end
      end
    end
  endtask

  task automatic test_frame_alignment();
    clear_mon();
    send_px(16'h7777, 2, 1);
    send_px(16'h7778, 3, 1);
    send_px(16'h7779, 0, 2);
    idle(4);
    n_cmp++; if (wt.size() !== 0) begin n_fail++; $display("FAIL align_dropped: got %0d windows want 0", wt.size()); end
    n_cmp++; if (bus.sync_err_o !== 1'b0) begin n_fail++; $display("FAIL align_sync_pre: got %b want 0", bus.sync_err_o); end
    clear_mon();
    send_frame(200, 0);
    idle(W + 4);
    n_cmp++; if (wt.size() !== N) begin n_fail++; $display("FAIL align_count: got %0d want %0d", wt.size(), N); end
    for (int i = 0; i < N && i < wt.size(); i++) begin
      n_cmp++;
      if ({wt[i], wm[i], wb[i]} !== exp_win(200, i)) begin
        n_fail++; $display("FAIL align_win%0d: got %0d,%0d,%0d want %h", i, wt[i], wm[i], wb[i], exp_win(200, i));
      end
    end
    n_cmp++; if (bus.sync_err_o !== 1'b0) begin n_fail++; $display("FAIL align_sync: got %b want 0", bus.sync_err_o); end
  endtask

  task automatic test_sync_err();
    clear_mon();
    for (int i = 0; i < N; i++) begin
      if (i == W + 2) begin
        n_cmp++; if (bus.sync_err_o !== 1'b0) begin n_fail++; $display("FAIL sync_before: got %b want 0", bus.sync_err_o); end
        send_px(pix(300, 2, 1), 3, 1);
        n_cmp++; if (bus.sync_err_o !== 1'b1) begin n_fail++; $display("FAIL sync_next: got %b want 1", bus.sync_err_o); end
      end else begin
        send_px(pix(300, i % W, i / W), i % W, i / W);
      end
    end
    idle(W + 4);
    n_cmp++; if (bus.sync_err_o !== 1'b1) begin n_fail++; $display("FAIL sync_sticky: got %b want 1", bus.sync_err_o); end
    n_cmp++; if (wt.size() !== N) begin n_fail++; $display("FAIL sync_count: got %0d want %0d", wt.size(), N); end
    for (int i = 0; i < N && i < wt.size(); i++) begin
      n_cmp++;
      if ({wt[i], wm[i], wb[i], wc[i], wr[i]} !== {exp_win(300, i), 16'(i % W), 16'(i / W)}) begin
        n_fail++; $display("FAIL sync_win%0d: got %0d,%0d,%0d @(%0d,%0d) want %h", i, wt[i], wm[i], wb[i], wc[i], wr[i], exp_win(300, i));
      end
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_cmp++; if (bus.sync_err_o !== 1'b0) begin n_fail++; $display("FAIL sync_clear: got %b want 0", bus.sync_err_o); end
  endtask

  task automatic test_mid_flush_reset();
    clear_mon();
    send_frame(400, 0);
    idle(2);
    n_cmp++; if ({bus.valid_o, bus.col_o} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL mflush_pre: valid %b col %0d want valid 1 col 1", bus.valid_o, bus.col_o);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL mflush_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL mflush_ready: got %b want 1", bus.ready_o); end
    idle(3);
    clear_mon();
    send_frame(500, 0);
    idle(W + 4);
    n_cmp++; if (wt.size() !== N) begin n_fail++; $display("FAIL mflush_count: got %0d want %0d", wt.size(), N); end
    for (int i = 0; i < N && i < wt.size(); i++) begin
      n_cmp++;
      if ({wt[i], wm[i], wb[i], wc[i], wr[i]} !== {exp_win(500, i), 16'(i % W), 16'(i / W)}) begin
        n_fail++; $display("FAIL mflush_win%0d: got %0d,%0d,%0d @(%0d,%0d) want %h", i, wt[i], wm[i], wb[i], wc[i], wr[i], exp_win(500, i));
      end
    end
  endtask

  initial begin
    bus.data_i  = '0;
    bus.col_i   = '0;
    bus.row_i   = '0;
    bus.valid_i = 1'b0;
    @(posedge clk); #2;
    test_reset();
    test_frame();
    test_bubbles();
    test_frame_alignment();
    test_sync_err();
    test_mid_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
